// File: rtl/ethernet_header_pkg.sv
// rtl/ethernet_header_pkg.sv - Ethernet framing types and constants shared by the RMII TX and RX paths
package ethernet_header_pkg;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } ethernet_header;

    localparam int          HEADER_BYTES   = 14;
    localparam int          FCS_BYTES      = 4;
    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_LAST_DIBIT = 2'b11;
    localparam logic [47:0] BROADCAST_MAC  = 48'hffffffffffff;

    // Wire order puts the first MAC byte in bits [7:0]; the MAC value has it at [47:40].
    function automatic logic [47:0] mac_from_wire(input logic [47:0] w);
        logic [47:0] m;
        for (int i = 0; i < 6; i++) begin
            m[47-8*i -: 8] = w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/crc_gen.sv
// rtl/crc_gen.sv - Dibit-serial Ethernet CRC-32 (reflected), crc_out is the complemented FCS value
module crc_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_en,
    input  logic [1:0]  data_in,
    output logic [31:0] crc_out
);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (crc_en) begin
            // data_in[0] is the earlier bit on the wire.
            for (int i = 0; i < 2; i++) begin
                crc_d = {1'b0, crc_d[31:1]} ^ ((crc_d[0] ^ data_in[i]) ? CRC_POLY : 32'h0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 32'hFFFFFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/packet_rx.sv
// rtl/packet_rx.sv - RMII frame receiver: preamble lock, MAC filter, payload to AXI-Stream words, FCS check
module packet_rx #(
    parameter logic [47:0] LOCAL_MAC            = 48'he86a64e7e830,
    parameter int          MII_WIDTH            = 2,
    parameter int          PACKET_PAYLOAD_WORDS = 64,
    parameter int          WORD_BYTES           = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_dv,
    input  logic [MII_WIDTH-1:0]    rxd,
    output logic [WORD_BYTES*8-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic [47:0]             rx_src_mac,
    output logic                    stat_good,
    output logic                    stat_crc_err,
    output logic                    stat_filtered,
    output logic                    stat_abort
);
    import ethernet_header_pkg::*;

    localparam int WORD_W         = WORD_BYTES * 8;
    localparam int BEATS_PER_WORD = WORD_W / MII_WIDTH;
    localparam int HDR_W          = HEADER_BYTES * 8;
    localparam int HDR_BEATS      = HDR_W / MII_WIDTH;
    localparam int DATA_BEATS     = PACKET_PAYLOAD_WORDS * BEATS_PER_WORD;
    localparam int FCS_BEATS      = FCS_BYTES * 8 / MII_WIDTH;
    localparam int CNT_W          = $clog2(DATA_BEATS + 1);
    localparam int WB_W           = $clog2(BEATS_PER_WORD + 1);

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_DATA, S_FCS, S_CHECK, S_DROP} state_t;

    state_t                        state_q, state_d;
    logic                          rx_dv_q;
    logic [MII_WIDTH-1:0]          rxd_q;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [WB_W-1:0]               wbeat_q, wbeat_d;
    // Shift registers omit the oldest dibit; the incoming dibit completes them combinationally.
    logic [HDR_W-MII_WIDTH-1:0]    hdr_q, hdr_d;
    logic [WORD_W-MII_WIDTH-1:0]   word_q, word_d;
    logic [31:0]                   fcs_q, fcs_d;
    logic [WORD_W-1:0]             pend_q, pend_d;
    logic                          pend_valid_q, pend_valid_d;
    logic                          ovf_q, ovf_d;
    logic                          abort_q, abort_d;
    logic [WORD_W-1:0]             tdata_q, tdata_d;
    logic                          tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [47:0]                   src_mac_q, src_mac_d;
    logic                          good_q, good_d, crc_err_q, crc_err_d;
    logic                          filt_q, filt_d, abort_p_q, abort_p_d;

    logic [HDR_W-1:0]  hdr_shift;
    logic [WORD_W-1:0] word_shift;
    logic [47:0]       dest_mac;
    logic              out_free, fcs_ok, crc_rst, crc_en;
    logic [31:0]       crc_out;

    assign crc_rst = rst || state_q == S_IDLE || state_q == S_PREAMBLE;
    assign crc_en  = state_q == S_HEADER || state_q == S_DATA;

    crc_gen u_crc (
        .clk     (clk),
        .rst     (crc_rst),
        .crc_en  (crc_en),
        .data_in (rxd_q),
        .crc_out (crc_out)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        wbeat_d      = wbeat_q;
        hdr_d        = hdr_q;
        word_d       = word_q;
        fcs_d        = fcs_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ovf_d        = ovf_q;
        abort_d      = abort_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q && !m_axis_tready;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        src_mac_d    = src_mac_q;
        good_d       = 1'b0;
        crc_err_d    = 1'b0;
        filt_d       = 1'b0;
        abort_p_d    = 1'b0;

        hdr_shift  = {rxd_q, hdr_q};
        word_shift = {rxd_q, word_q};
        dest_mac   = mac_from_wire(hdr_shift[47:0]);
        out_free   = !tvalid_q || m_axis_tready;
        fcs_ok     = fcs_q == crc_out;

        // Loss of carrier inside the frame body flushes any pending word as a bad last beat.
        if (!rx_dv_q && (state_q == S_HEADER || state_q == S_DATA || state_q == S_FCS)) begin
            abort_p_d = 1'b1;
            abort_d   = pend_valid_q;
            state_d   = pend_valid_q ? S_CHECK : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d        = '0;
                    ovf_d        = 1'b0;
                    abort_d      = 1'b0;
                    pend_valid_d = 1'b0;
                    if (rx_dv_q) begin
                        state_d = (rxd_q == PREAMBLE_DIBIT) ? S_PREAMBLE : S_DROP;
                    end
                end
                S_PREAMBLE: begin
                    cnt_d   = '0;
                    wbeat_d = '0;
                    if (!rx_dv_q) begin
                        state_d = S_IDLE;
                    end else if (rxd_q == SFD_LAST_DIBIT) begin
                        state_d = S_HEADER;
                    end else if (rxd_q != PREAMBLE_DIBIT) begin
                        state_d = S_DROP;
                    end
                end
                S_HEADER: begin
                    hdr_d = hdr_shift[HDR_W-1:MII_WIDTH];
                    if (cnt_q == CNT_W'(HDR_BEATS - 1)) begin
                        cnt_d = '0;
                        if (dest_mac == LOCAL_MAC || dest_mac == BROADCAST_MAC) begin
                            src_mac_d = mac_from_wire(hdr_shift[95:48]);
                            state_d   = S_DATA;
                        end else begin
                            filt_d  = 1'b1;
                            state_d = S_DROP;
                        end
                    end
                end
                S_DATA: begin
                    word_d  = word_shift[WORD_W-1:MII_WIDTH];
                    wbeat_d = wbeat_q + WB_W'(1);
                    if (wbeat_q == WB_W'(BEATS_PER_WORD - 1)) begin
                        wbeat_d      = '0;
                        pend_d       = word_shift;
                        pend_valid_d = 1'b1;
                        if (pend_valid_q) begin
                            if (out_free) begin
                                tdata_d  = pend_q;
                                tvalid_d = 1'b1;
                                tlast_d  = 1'b0;
                                tuser_d  = 1'b0;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    if (cnt_q == CNT_W'(DATA_BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FCS;
                    end
                end
                S_FCS: begin
                    fcs_d = {rxd_q, fcs_q[31:MII_WIDTH]};
                    if (cnt_q == CNT_W'(FCS_BEATS - 1)) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (out_free) begin
                        tdata_d      = pend_q;
                        tvalid_d     = 1'b1;
                        tlast_d      = 1'b1;
                        tuser_d      = abort_q || ovf_q || !fcs_ok;
                        pend_valid_d = 1'b0;
                        good_d       = !abort_q && fcs_ok;
                        crc_err_d    = !abort_q && !fcs_ok;
                        state_d      = abort_q ? S_IDLE : S_DROP;
                    end
                end
                S_DROP: begin
                    if (!rx_dv_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_dv_q      <= 1'b0;
            rxd_q        <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wbeat_q      <= '0;
            hdr_q        <= '0;
            word_q       <= '0;
            fcs_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            abort_q      <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            src_mac_q    <= '0;
            good_q       <= 1'b0;
            crc_err_q    <= 1'b0;
            filt_q       <= 1'b0;
            abort_p_q    <= 1'b0;
        end else begin
            rx_dv_q      <= rx_dv;
            rxd_q        <= rxd;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wbeat_q      <= wbeat_d;
            hdr_q        <= hdr_d;
            word_q       <= word_d;
            fcs_q        <= fcs_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ovf_q        <= ovf_d;
            abort_q      <= abort_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            src_mac_q    <= src_mac_d;
            good_q       <= good_d;
            crc_err_q    <= crc_err_d;
            filt_q       <= filt_d;
            abort_p_q    <= abort_p_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign rx_src_mac    = src_mac_q;
    assign stat_good     = good_q;
    assign stat_crc_err  = crc_err_q;
    assign stat_filtered = filt_q;
    assign stat_abort    = abort_p_q;

endmodule

// File: tb/tb_packet_rx.sv
// tb/tb_packet_rx.sv - Directed frame bench for packet_rx with a byte-level frame and CRC model
module tb_packet_rx;

    localparam logic [47:0] LOCAL = 48'he86a64e7e830;
    localparam logic [47:0] SRC_A = 48'h020000000001;
    localparam logic [47:0] SRC_B = 48'h0a1b2c3d4e5f;
    localparam logic [47:0] SRC_C = 48'h020000000077;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk, rst, rx_dv, tready;
    logic [1:0]  rxd;
    logic [31:0] tdata;
    logic        tvalid, tlast, tuser;
    logic [47:0] src_mac;
    logic        s_good, s_crc, s_filt, s_abort;

    int          total = 0;
    int          bad = 0;
    int          n_good = 0, n_crc = 0, n_filt = 0, n_abort = 0;
    beat_t       exp_q[$];
    logic [31:0] pay[64];
    logic        hold;
    logic [31:0] hold_data;

    packet_rx #(
        .LOCAL_MAC            (LOCAL),
        .MII_WIDTH            (2),
        .PACKET_PAYLOAD_WORDS (64),
        .WORD_BYTES           (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_dv         (rx_dv),
        .rxd           (rxd),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .m_axis_tready (tready),
        .rx_src_mac    (src_mac),
        .stat_good     (s_good),
        .stat_crc_err  (s_crc),
        .stat_filtered (s_filt),
        .stat_abort    (s_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // IEEE 802.3 CRC-32 over bytes taken LSB first; result is the FCS value.
    function automatic logic [31:0] crc32(input bytes_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB88320;
                else                c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic logic [31:0] wire_word(input int i, input int flip);
        logic [31:0] w;
        w = pay[i];
        if (flip >= 0 && flip / 4 == i) w[8*(flip%4)] = ~w[8*(flip%4)];
        return w;
    endfunction

    // n words reach the stream; the last one carries tlast and the given tuser.
    task automatic expect_frame(input int n, input int flip, input logic user);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = wire_word(i, flip);
            b.l = (i == n - 1);
            b.u = (i == n - 1) ? user : 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic drive(input logic dv, input logic [1:0] d);
        @(posedge clk);
        #1;
        rx_dv = dv;
        rxd   = d;
    endtask

    task automatic send_frame(input logic [47:0] dest, input logic [47:0] src,
                              input int flip, input int cut);
        bytes_t body, wire_b;
        logic [31:0] fcs;
        logic        stop;
        int          g;
        for (int i = 0; i < 6; i++) body.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(src[47-8*i -: 8]);
        body.push_back(8'h88);
        body.push_back(8'hB5);
        for (int w = 0; w < 64; w++)
            for (int k = 0; k < 4; k++) body.push_back(pay[w][8*k +: 8]);
        fcs = crc32(body);
        if (flip >= 0) body[14 + flip] = body[14 + flip] ^ 8'h01;
        for (int i = 0; i < 7; i++) wire_b.push_back(8'h55);
        wire_b.push_back(8'hD5);
        foreach (body[i]) wire_b.push_back(body[i]);
        for (int k = 0; k < 4; k++) wire_b.push_back(fcs[8*k +: 8]);
        stop = 1'b0;
        foreach (wire_b[j]) begin
            for (int k = 0; k < 4; k++) begin
                g = j * 4 + k;
                if (cut >= 0 && g >= 88 + cut) stop = 1'b1;
                if (!stop) drive(1'b1, wire_b[j][2*k +: 2]);
            end
        end
        drive(1'b0, 2'b00);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        repeat (20) @(posedge clk);
    endtask

    task automatic run_frame(input string name, input logic [47:0] dest, input logic [47:0] src,
                             input int flip, input int cut,
                             input int eg, input int ec, input int ef, input int ea);
        int g0, c0, f0, a0;
        g0 = n_good; c0 = n_crc; f0 = n_filt; a0 = n_abort;
        send_frame(dest, src, flip, cut);
        drain(name);
        chk({name, "_stat_good"},  64'(n_good - g0),  64'(eg));
        chk({name, "_stat_crc"},   64'(n_crc - c0),   64'(ec));
        chk({name, "_stat_filt"},  64'(n_filt - f0),  64'(ef));
        chk({name, "_stat_abort"}, 64'(n_abort - a0), 64'(ea));
    endtask

    // Handshake happens at the next posedge when valid and ready are both high at the negedge.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            hold <= 1'b0;
        end else begin
            n_good  += int'(s_good);
            n_crc   += int'(s_crc);
            n_filt  += int'(s_filt);
            n_abort += int'(s_abort);
            if (hold) begin
                chk("hold_valid", 64'(tvalid), 64'd1);
                chk("hold_data", 64'(tdata), 64'(hold_data));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", 64'(tdata), 64'(b.d));
                    chk("beat_last", 64'(tlast), 64'(b.l));
                    if (b.l) chk("beat_user", 64'(tuser), 64'(b.u));
                end
            end
            hold      <= tvalid && !tready;
            hold_data <= tdata;
        end
    end

    initial begin
        bytes_t probe;
        string  s;
        beat_t  b;
        rst = 1'b1; rx_dv = 1'b0; rxd = 2'b00; tready = 1'b1;
        for (int i = 0; i < 64; i++) pay[i] = 32'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata",  64'(tdata),  64'd0);
        chk("rst_tlast",  64'(tlast),  64'd0);
        chk("rst_tuser",  64'(tuser),  64'd0);
        chk("rst_src",    64'(src_mac), 64'd0);
        chk("rst_stats",  64'({s_good, s_crc, s_filt, s_abort}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        s = "123456789";
        for (int i = 0; i < s.len(); i++) probe.push_back(8'(s[i]));
        chk("model_crc_check_value", 64'(crc32(probe)), 64'hCBF43926);
        chk("model_flip_word", 64'(wire_word(2, 10)), 64'h00010002);

        expect_frame(64, -1, 1'b0);
        run_frame("good", LOCAL, SRC_A, -1, -1, 1, 0, 0, 0);
        chk("good_src_mac", 64'(src_mac), 64'(SRC_A));

        expect_frame(64, 10, 1'b1);
        run_frame("crc_err", LOCAL, SRC_A, 10, -1, 0, 1, 0, 0);

        run_frame("filtered", 48'h112233445566, SRC_C, -1, -1, 0, 0, 1, 0);
        chk("filtered_src_kept", 64'(src_mac), 64'(SRC_A));

        for (int i = 0; i < 64; i++) pay[i] = 32'hDEAD0000 ^ (32'(i) * 32'h01030507);
        expect_frame(64, -1, 1'b0);
        run_frame("broadcast", 48'hffffffffffff, SRC_B, -1, -1, 1, 0, 0, 0);
        chk("broadcast_src_mac", 64'(src_mac), 64'(SRC_B));

        for (int i = 0; i < 64; i++) pay[i] = 32'(i);
        expect_frame(5, -1, 1'b1);
        run_frame("abort", LOCAL, SRC_A, -1, 5 * 16, 0, 0, 0, 1);
        expect_frame(64, -1, 1'b0);
        run_frame("after_abort", LOCAL, SRC_A, -1, -1, 1, 0, 0, 0);

        // Output stalled for the whole frame: only word 0 and the final word survive.
        @(posedge clk);
        #1 tready = 1'b0;
        b.d = pay[0];  b.l = 1'b0; b.u = 1'b0; exp_q.push_back(b);
        b.d = pay[63]; b.l = 1'b1; b.u = 1'b1; exp_q.push_back(b);
        send_frame(LOCAL, SRC_A, -1, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("stall_tvalid", 64'(tvalid), 64'd1);
        chk("stall_tdata",  64'(tdata),  64'd0);
        chk("stall_tlast",  64'(tlast),  64'd0);
        @(posedge clk);
        #1 tready = 1'b1;
        drain("overflow");
        expect_frame(64, -1, 1'b0);
        run_frame("after_overflow", LOCAL, SRC_A, -1, -1, 1, 0, 0, 0);

        // Reset 8 dibits into word 10: words 0..8 have left, word 9 is pending and lost.
        expect_frame(9, -1, 1'b0);
        exp_q[8].l = 1'b0;
        begin
            int a0, g0;
            a0 = n_abort; g0 = n_good;
            send_frame(LOCAL, SRC_B, -1, 10 * 16 + 8);
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("midrst_tvalid", 64'(tvalid), 64'd0);
            chk("midrst_tlast",  64'(tlast),  64'd0);
            chk("midrst_src",    64'(src_mac), 64'd0);
            drain("midrst");
            chk("midrst_no_abort", 64'(n_abort - a0), 64'd0);
            chk("midrst_no_good",  64'(n_good - g0),  64'd0);
        end
        expect_frame(64, -1, 1'b0);
        run_frame("after_rst", LOCAL, SRC_A, -1, -1, 1, 0, 0, 0);
        chk("after_rst_src_mac", 64'(src_mac), 64'(SRC_A));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
